x0_receiver: RTL and testbench

- Downstream consumer of the X0 transmit sequencer.
- Captures the four data bits X0 presents on Dt, each indexed by bit1:bit0 and strobed by A.
- Answers every strobe with a four-phase ack; once all four positions are filled, asserts senack and presents the assembled 4-bit word.
- Cclear from X0 releases senack and empties the word for the next transfer.

---
 rtl/x0_receiver.sv | 136 +++++++++++++
 tb/tb_x0_receiver.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/x0_receiver.sv
// x0_receiver: bit-serial receiver answering the X0 transmit sequencer.
// Captures four indexed data bits via a four-phase ack, then presents the word.
module x0_receiver #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       A,
   input  logic       Dt,
   input  logic       bit0,
   input  logic       bit1,
   input  logic       Cclear,
   output logic       ack,
   output logic       senack,
   output logic [3:0] data,
   output logic       err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_ABORT = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int CW = (TIMEOUT_CYCLES > 1) ?
                       $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] TMAX  = CW'(TIMEOUT_CYCLES);
   localparam bit            TO_EN = (TIMEOUT_CYCLES != 0);

   logic [4:0]    sync_q [SYNC_STAGES];
   logic          a_s, dt_s, b0_s, b1_s, cclear_s;
   logic [1:0]    idx;
   logic [1:0]    state;
   logic [3:0]    word, got;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nx;
   logic [3:0]    word_c, got_c, word_cap, got_cap;
   logic          err_c, dup;

   // Synchronise all X0 control/data lines through equal-depth chains
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= {Cclear, bit1, bit0, Dt, A};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign {cclear_s, b1_s, b0_s, dt_s, a_s} = sync_q[SYNC_STAGES-1];
   assign idx    = {b1_s, b0_s};
   assign cnt_nx = cnt + 1'b1;

   // Clear is applied ahead of any capture in the same cycle
   always_comb begin
      word_c        = cclear_s ? 4'd0 : word;
      got_c         = cclear_s ? 4'd0 : got;
      err_c         = cclear_s ? 1'b0 : err;
      dup           = got_c[idx];
      word_cap      = word_c;
      word_cap[idx] = dt_s;
      got_cap       = got_c;
      got_cap[idx]  = 1'b1;
   end

   // Handshake sequencer, word assembly and sticky error tracking
   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= S_IDLE;
         ack    <= 1'b0;
         senack <= 1'b0;
         data   <= 4'd0;
         err    <= 1'b0;
         word   <= 4'd0;
         got    <= 4'd0;
         cnt    <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (a_s) begin
                  word  <= word_cap;
                  got   <= got_cap;
                  err   <= err_c | dup;
                  ack   <= 1'b1;
                  cnt   <= '0;
                  state <= S_WAIT;
               end else begin
                  word <= word_c;
                  got  <= got_c;
                  err  <= err_c;
               end
            end
            S_WAIT: begin
               word <= word_c;
               got  <= got_c;
               err  <= err_c;
               if (!a_s) begin
                  ack <= 1'b0;
                  cnt <= '0;
                  if (got_c == 4'hf) begin
                     senack <= 1'b1;
                     data   <= word_c;
                     state  <= S_DONE;
                  end else begin
                     state <= S_IDLE;
                  end
               end else if (TO_EN && cnt_nx == TMAX) begin
                  err   <= 1'b1;
                  ack   <= 1'b0;
                  got   <= 4'd0;
                  word  <= 4'd0;
                  cnt   <= '0;
                  state <= S_ABORT;
               end else begin
                  cnt <= cnt_nx;
               end
            end
            S_ABORT: begin
               if (!a_s) state <= S_IDLE;
            end
            S_DONE: begin
               if (cclear_s) begin
                  senack <= 1'b0;
                  data   <= 4'd0;
                  word   <= 4'd0;
                  got    <= 4'd0;
                  err    <= 1'b0;
                  state  <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_x0_receiver.sv
// tb_x0_receiver: directed vector bench for x0_receiver.
// Table-driven strobes plus hand sequences for timeout, DONE and reset.
module tb_x0_receiver;

   localparam int SS = 2;
   localparam int TO = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       A = 1'b0, Dt = 1'b0, bit0 = 1'b0, bit1 = 1'b0;
   logic       Cclear = 1'b0;
   logic       ack, senack, err;
   logic [3:0] data;

   int tests = 0;
   int fails = 0;

   x0_receiver #(.SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .A(A), .Dt(Dt),
      .bit0(bit0), .bit1(bit1), .Cclear(Cclear),
      .ack(ack), .senack(senack), .data(data), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] idx;
      logic       dt;
      logic       sen;
      logic [3:0] dat;
      logic       er;
      logic       clr;
   } vec_t;

   vec_t v[13];

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic strobe(input logic [1:0] i, input logic d);
      int n;
      bit1 = i[1]; bit0 = i[0]; Dt = d; A = 1'b1;
      n = 0;
      do begin
         @(posedge clk); n++; @(negedge clk);
      end while (!ack && n < 40);
      chk("ack_latency", n, SS + 1);
      A = 1'b0;
      n = 0;
      do begin
         @(posedge clk); n++; @(negedge clk);
      end while (ack && n < 40);
      chk("ack_fall_bound", int'(n < 40), 1);
   endtask

   task automatic clear_word();
      Cclear = 1'b1;
      repeat (SS + 1) @(posedge clk);
      @(negedge clk);
      chk("clr_senack", senack, 0);
      chk("clr_data", data, 0);
      chk("clr_err", err, 0);
      Cclear = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int  n;
      bit  fell, reack, saw;

      v[0]  = '{2'd0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0};
      v[1]  = '{2'd1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
      v[2]  = '{2'd2, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0};
      v[3]  = '{2'd3, 1'b1, 1'b1, 4'hd, 1'b0, 1'b1};
      v[4]  = '{2'd3, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
      v[5]  = '{2'd1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0};
      v[6]  = '{2'd0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0};
      v[7]  = '{2'd2, 1'b0, 1'b1, 4'h3, 1'b0, 1'b1};
      v[8]  = '{2'd2, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
      v[9]  = '{2'd2, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0};
      v[10] = '{2'd0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0};
      v[11] = '{2'd1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0};
      v[12] = '{2'd3, 1'b1, 1'b1, 4'hf, 1'b1, 1'b1};

      // reset held with A toggling
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         A = ~A;
         @(negedge clk);
         chk("rst_outputs", {ack, senack, data, err}, 0);
      end
      A = 1'b0;
      reset = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("post_rst_outputs", {ack, senack, data, err}, 0);
      end

      // table-driven transfers
      for (int k = 0; k < 13; k++) begin
         strobe(v[k].idx, v[k].dt);
         chk($sformatf("v%0d_senack", k), senack, v[k].sen);
         chk($sformatf("v%0d_data", k), data, v[k].dat);
         chk($sformatf("v%0d_err", k), err, v[k].er);
         if (v[k].clr) clear_word();
      end

      // timeout: A held high long after ack
      bit1 = 1'b0; bit0 = 1'b0; Dt = 1'b1; A = 1'b1;
      n = 0;
      do begin
         @(posedge clk); n++; @(negedge clk);
      end while (!ack && n < 40);
      chk("to_ack_latency", n, SS + 1);
      fell = 1'b0; reack = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!ack) fell = 1'b1;
         else if (fell) reack = 1'b1;
      end
      chk("to_ack_fell", fell, 1);
      chk("to_no_reack", reack, 0);
      chk("to_err", err, 1);
      A = 1'b0;
      repeat (4) @(negedge clk);
      chk("to_ack_low", ack, 0);
      for (int k = 0; k < 4; k++) begin
         logic [1:0] ki;
         ki = 2'(k);
         strobe(ki, ki[0]);
      end
      chk("to_next_senack", senack, 1);
      chk("to_next_data", data, 4'b1010);
      chk("to_next_err", err, 1);

      // strobe while in DONE is ignored
      bit1 = 1'b1; bit0 = 1'b0; Dt = 1'b0; A = 1'b1;
      saw = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (ack) saw = 1'b1;
      end
      chk("done_no_ack", saw, 0);
      chk("done_data", data, 4'b1010);
      chk("done_senack", senack, 1);
      A = 1'b0;
      repeat (4) @(negedge clk);
      clear_word();

      // reset during WAIT_LOW
      bit1 = 1'b0; bit0 = 1'b1; Dt = 1'b1; A = 1'b1;
      n = 0;
      do begin
         @(posedge clk); n++; @(negedge clk);
      end while (!ack && n < 40);
      chk("wr_ack_rise", ack, 1);
      reset = 1'b0;
      @(negedge clk);
      chk("wr_rst_outputs", {ack, senack, data, err}, 0);
      A = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("wr_after_rst", {ack, senack, data, err}, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
